wb_cdc_arbiter: RTL and testbench
=================================

// Module: wb_cdc_arbiter
// PURPOSE
//  Round-robin Wishbone classic arbiter sharing one downstream single-beat port (the master side of the
//  clock-domain crossing bridge) between NUM requesting masters, all in one clock domain.
//  Adds a per-transaction watchdog: a stalled slave is answered with err, then drained before re-grant,
//  so a late ack from the bridge is never misrouted.
// PARAMETERS
//  NUM      4    number of requesting masters (2..8)
//  AW       32   address width
//  TIMEOUT  255  max cycles in GRANT without ack before err; 0 disables watchdog
// PORTS
//  wb_clk      in   1       clock
//  wb_rst      in   1       synchronous reset, active high
//  wbm_adr_i   in   NUM*AW  master addresses, master k at [k*AW +: AW]
//  wbm_dat_i   in   NUM*32  master write data
//  wbm_sel_i   in   NUM*4   master byte selects
//  wbm_we_i    in   NUM     master write enables
//  wbm_cyc_i   in   NUM     master cycle
//  wbm_stb_i   in   NUM     master strobe
//  wbm_dat_o   out  32      read data, shared by all masters (= wbs_dat_i)
//  wbm_ack_o   out  NUM     per-master ack
//  wbm_err_o   out  NUM     per-master err (watchdog expiry)
//  wbs_adr_o   out  AW      downstream address
//  wbs_dat_o   out  32      downstream write data
//  wbs_sel_o   out  4       downstream byte selects
//  wbs_we_o    out  1       downstream write enable
//  wbs_cyc_o   out  1       downstream cycle
//  wbs_stb_o   out  1       downstream strobe (always equals wbs_cyc_o)
//  wbs_dat_i   in   32      downstream read data
//  wbs_ack_i   in   1       downstream ack
//  gnt_o       out  NUM     one-hot current grant (debug/status), 0 when idle
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, gnt 0, timer 0; wbs_cyc_o/stb_o/we_o 0, wbm_ack_o/err_o 0.
//    Reset mid-transaction abandons it; no ack/err emitted; downstream ack arriving later is ignored.
//  - req[k] = wbm_cyc_i[k] & wbm_stb_i[k].
//  - IDLE: if any req, register one-hot gnt = first req at or after rr pointer (wrapping NUM-1 -> 0);
//    go GRANT. Latency: request seen cycle n -> wbs_cyc_o high cycle n+1.
//  - GRANT: wbs_adr/dat/sel/we muxed from granted master (registered gnt, combinational mux);
//    wbs_cyc_o = wbs_stb_o = req[gnt]. Timer increments each cycle.
//    * wbs_ack_i=1: wbm_ack_o[gnt]=1 same cycle (comb), rr pointer = gnt index+1 mod NUM, -> IDLE.
//    * timer == TIMEOUT-1 (TIMEOUT!=0) and no ack: wbm_err_o[gnt]=1 for one cycle, -> DRAIN.
//    * req[gnt] drops with no ack (master abort): -> DRAIN, no ack/err.
//    * ack and timeout same cycle: ack wins, no err.
//  - DRAIN: wbs_cyc_o=0, gnt held; wait for wbs_ack_i, discard (no wbm_ack_o), advance rr pointer,
//    -> IDLE. Watchdog inactive; DRAIN persists until downstream acks (bridge must complete).
//  - Non-granted masters never see ack/err. At most one bit of wbm_ack_o|wbm_err_o set per cycle.
//  - At least one IDLE cycle between consecutive downstream transactions (wbs_cyc_o low >= 1 cycle),
//    so the bridge always sees a fresh cyc&stb edge.
//  - Timer width: clog2(TIMEOUT+1); cleared on entry to GRANT; never wraps.
//  - wbm_dat_o is wbs_dat_i unconditionally; valid only with the matching ack.
// STRUCTURE
//  - State encoding (IDLE/GRANT/DRAIN) as localparams in wb_cdc_arbiter; no shared package needed.
//  - One sub-module: wb_rr_pick (NUM req, NUM-bit one-hot last grant in -> one-hot next grant,
//    purely combinational rotate-priority-rotate). Reused by future arbiters.
// TESTING
//  1. Single master 1, read: req cycle 0, bridge acks cycle 5 with 0xCAFEF00D -> wbs_cyc_o high
//     cycles 1..5, wbm_ack_o=4'b0010 cycle 5, wbm_dat_o=0xCAFEF00D, gnt_o=0 cycle 6.
//  2. All 4 masters request continuously, slave acks after 2 cycles -> grant order 0,1,2,3,0,...
//     each ack on correct bit, idle gap of 1 cycle between transactions.
//  3. TIMEOUT=8, slave never acks then acks at cycle 20 -> wbm_err_o[gnt] pulse at 8th GRANT cycle,
//     wbs_cyc_o low from next cycle, late ack produces no wbm_ack_o, next grant only after it.
//  4. Ack coincides with last timeout cycle -> ack delivered, no err, no DRAIN.
//  5. Master 2 drops cyc mid-transaction; master 3 requesting -> DRAIN until ack, ack discarded,
//     master 3 granted after drain with its own address.
//  6. Assert wb_rst during GRANT -> all outputs 0 next cycle, pending ack ignored, rr pointer back to 0.

Source files
------------

// File: rtl/wb_cdc_arbiter_pkg.sv
// Shared helpers for the Wishbone CDC arbiter.
// Holds constant functions used to size arbiter internals.
package wb_cdc_arbiter_pkg;

    // Bits needed to count 0..timeout without wrapping; at least one bit.
    function automatic int unsigned timer_width(input int unsigned timeout);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) <= 64'(timeout)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin pick: one-hot next grant from requests and one-hot last grant.
// Purely combinational rotate, isolate-lowest, rotate back.
module wb_rr_pick #(
    parameter int NUM = 4
) (
    input  logic [NUM-1:0] req_i,
    input  logic [NUM-1:0] last_i,
    output logic [NUM-1:0] gnt_o
);

    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [IW-1:0]    sh;
    logic [2*NUM-1:0] dbl_req;
    logic [2*NUM-1:0] dbl_gnt;
    logic [NUM-1:0]   rot;
    logic [NUM-1:0]   pick;

    always_comb begin
        sh = '0;
        for (int i = 0; i < NUM; i++) begin
            if (last_i[i]) begin
                sh = IW'((i + 1) % NUM);
            end
        end
        dbl_req = {req_i, req_i} >> sh;
        rot     = dbl_req[NUM-1:0];
        // Two's-complement trick isolates the lowest set bit.
        pick    = rot & (~rot + NUM'(1));
        dbl_gnt = {pick, pick} << sh;
        gnt_o   = dbl_gnt[2*NUM-1:NUM];
    end

endmodule

// File: rtl/wb_cdc_arbiter.sv
// Round-robin Wishbone classic arbiter in front of a single-beat CDC bridge port.
// A watchdog answers stalled transfers with err, then drains the bridge before re-grant.
module wb_cdc_arbiter #(
    parameter int NUM     = 4,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic [NUM*AW-1:0] wbm_adr_i,
    input  logic [NUM*32-1:0] wbm_dat_i,
    input  logic [NUM*4-1:0]  wbm_sel_i,
    input  logic [NUM-1:0]    wbm_we_i,
    input  logic [NUM-1:0]    wbm_cyc_i,
    input  logic [NUM-1:0]    wbm_stb_i,
    output logic [31:0]       wbm_dat_o,
    output logic [NUM-1:0]    wbm_ack_o,
    output logic [NUM-1:0]    wbm_err_o,
    output logic [AW-1:0]     wbs_adr_o,
    output logic [31:0]       wbs_dat_o,
    output logic [3:0]        wbs_sel_o,
    output logic              wbs_we_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    input  logic [31:0]       wbs_dat_i,
    input  logic              wbs_ack_i,
    output logic [NUM-1:0]    gnt_o
);

    import wb_cdc_arbiter_pkg::*;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int unsigned  TW     = timer_width(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    logic [1:0]     state_q, state_d;
    logic [NUM-1:0] gnt_q, gnt_d;
    logic [NUM-1:0] last_q, last_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [NUM-1:0] req;
    logic [NUM-1:0] pick;
    logic           req_g;

    assign req   = wbm_cyc_i & wbm_stb_i;
    assign req_g = |(req & gnt_q);

    wb_rr_pick #(
        .NUM(NUM)
    ) u_pick (
        .req_i (req),
        .last_i(last_q),
        .gnt_o (pick)
    );

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (gnt_q[k]) begin
                wbs_adr_o = wbm_adr_i[k*AW +: AW];
                wbs_dat_o = wbm_dat_i[k*32 +: 32];
                wbs_sel_o = wbm_sel_i[k*4 +: 4];
                wbs_we_o  = wbm_we_i[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        timer_d   = timer_q;
        wbs_cyc_o = 1'b0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    timer_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                wbs_cyc_o = req_g;
                if (timer_q != T_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                if (wbs_ack_i) begin
                    // An ack racing a master abort is retired without delivery.
                    if (req_g) begin
                        wbm_ack_o = gnt_q;
                    end
                    last_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (!req_g) begin
                    state_d = ST_DRAIN;
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    wbm_err_o = gnt_q;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wbs_ack_i) begin
                    last_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // rr pointer 0 is held as "last granted NUM-1".
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= {1'b1, {(NUM-1){1'b0}}};
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    assign wbs_stb_o = wbs_cyc_o;
    assign wbm_dat_o = wbs_dat_i;
    assign gnt_o     = gnt_q;

endmodule

// File: tb/tb_wb_cdc_arbiter.sv
// Directed bench for wb_cdc_arbiter: vector table plus hand-written corner sequences.
// Runs with NUM=4, AW=32, TIMEOUT=8.
module tb_wb_cdc_arbiter;

    localparam int NUM = 4;
    localparam int AW  = 32;
    localparam logic [31:0] RDATA = 32'hCAFEF00D;

    logic              clk;
    logic              wb_rst;
    logic [NUM*AW-1:0] wbm_adr_i;
    logic [NUM*32-1:0] wbm_dat_i;
    logic [NUM*4-1:0]  wbm_sel_i;
    logic [NUM-1:0]    wbm_we_i;
    logic [NUM-1:0]    wbm_cyc_i;
    logic [NUM-1:0]    wbm_stb_i;
    logic [31:0]       wbm_dat_o;
    logic [NUM-1:0]    wbm_ack_o;
    logic [NUM-1:0]    wbm_err_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [31:0]       wbs_dat_o;
    logic [3:0]        wbs_sel_o;
    logic              wbs_we_o;
    logic              wbs_cyc_o;
    logic              wbs_stb_o;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_i;
    logic [NUM-1:0]    gnt_o;

    int checks;
    int errors;

    wb_cdc_arbiter #(
        .NUM(NUM),
        .AW(AW),
        .TIMEOUT(8)
    ) dut (
        .wb_clk   (clk),
        .wb_rst   (wb_rst),
        .wbm_adr_i(wbm_adr_i),
        .wbm_dat_i(wbm_dat_i),
        .wbm_sel_i(wbm_sel_i),
        .wbm_we_i (wbm_we_i),
        .wbm_cyc_i(wbm_cyc_i),
        .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o),
        .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o),
        .wbs_dat_o(wbs_dat_o),
        .wbs_sel_o(wbs_sel_o),
        .wbs_we_o (wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o),
        .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i),
        .wbs_ack_i(wbs_ack_i),
        .gnt_o    (gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic       cyc;
        logic [3:0] ack_o;
    } vec_t;

    vec_t tv[$];

    function automatic int oh_idx(input logic [3:0] g);
        int r;
        r = 0;
        for (int i = 0; i < NUM; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic a);
        wbm_cyc_i = r;
        wbm_stb_i = r;
        wbs_ack_i = a;
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [3:0] g, input logic c,
                        input logic [3:0] a, input logic [3:0] e);
        int k;
        @(negedge clk);
        check({tag, " gnt"}, 32'(gnt_o), 32'(g));
        check({tag, " cyc"}, 32'(wbs_cyc_o), 32'(c));
        check({tag, " stb"}, 32'(wbs_stb_o), 32'(c));
        check({tag, " ack"}, 32'(wbm_ack_o), 32'(a));
        check({tag, " err"}, 32'(wbm_err_o), 32'(e));
        if (c) begin
            k = oh_idx(g);
            check({tag, " adr"}, wbs_adr_o, 32'h1000_0000 + 32'(k) * 32'h100);
            check({tag, " wdat"}, wbs_dat_o, 32'hD000_0000 + 32'(k));
            check({tag, " sel"}, 32'(wbs_sel_o), 32'(k + 1));
            check({tag, " we"}, 32'(wbs_we_o), 32'(k % 2));
        end
        if (a != 4'b0) begin
            check({tag, " rdat"}, wbm_dat_o, RDATA);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] r, input logic a, input logic [3:0] g,
                       input logic c, input logic [3:0] ao);
        vec_t v;
        v.req   = r;
        v.ack   = a;
        v.gnt   = g;
        v.cyc   = c;
        v.ack_o = ao;
        tv.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wbs_dat_i = RDATA;
        for (int k = 0; k < NUM; k++) begin
            wbm_adr_i[k*32 +: 32] = 32'h1000_0000 + 32'(k) * 32'h100;
            wbm_dat_i[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            wbm_sel_i[k*4 +: 4]   = 4'(k + 1);
            wbm_we_i[k]           = (k % 2 == 1);
        end

        // All masters request continuously, ack on second grant cycle.
        add(4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(4'b1111, 0, 4'b0001, 1, 4'b0000);
        add(4'b1111, 1, 4'b0001, 1, 4'b0001);
        add(4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(4'b1111, 0, 4'b0010, 1, 4'b0000);
        add(4'b1111, 1, 4'b0010, 1, 4'b0010);
        add(4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(4'b1111, 0, 4'b0100, 1, 4'b0000);
        add(4'b1111, 1, 4'b0100, 1, 4'b0100);
        add(4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(4'b1111, 0, 4'b1000, 1, 4'b0000);
        add(4'b1111, 1, 4'b1000, 1, 4'b1000);
        add(4'b1111, 0, 4'b0000, 0, 4'b0000);
        add(4'b1111, 0, 4'b0001, 1, 4'b0000);
        add(4'b1111, 1, 4'b0001, 1, 4'b0001);
        add(4'b0000, 0, 4'b0000, 0, 4'b0000);
        // Single master 1 read, ack at cycle 5.
        add(4'b0010, 0, 4'b0000, 0, 4'b0000);
        add(4'b0010, 0, 4'b0010, 1, 4'b0000);
        add(4'b0010, 0, 4'b0010, 1, 4'b0000);
        add(4'b0010, 0, 4'b0010, 1, 4'b0000);
        add(4'b0010, 0, 4'b0010, 1, 4'b0000);
        add(4'b0010, 1, 4'b0010, 1, 4'b0010);
        add(4'b0000, 0, 4'b0000, 0, 4'b0000);

        wb_rst = 1'b1;
        drive(4'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        wb_rst = 1'b0;
        step("reset", 4'b0, 0, 4'b0, 4'b0);

        foreach (tv[i]) begin
            drive(tv[i].req, tv[i].ack);
            step($sformatf("vec%0d", i), tv[i].gnt, tv[i].cyc, tv[i].ack_o, 4'b0);
        end

        // Watchdog expiry, drain, late ack discarded, re-grant afterwards.
        drive(4'b0001, 0);
        step("to c0", 4'b0, 0, 4'b0, 4'b0);
        for (int c = 1; c <= 8; c++) begin
            drive(4'b0001, 0);
            step($sformatf("to c%0d", c), 4'b0001, 1, 4'b0,
                 (c == 8) ? 4'b0001 : 4'b0000);
        end
        for (int c = 9; c <= 19; c++) begin
            drive(4'b0010, 0);
            step($sformatf("drain c%0d", c), 4'b0001, 0, 4'b0, 4'b0);
        end
        drive(4'b0010, 1);
        step("late ack", 4'b0001, 0, 4'b0, 4'b0);
        drive(4'b0010, 0);
        step("post drain idle", 4'b0, 0, 4'b0, 4'b0);
        step("regrant", 4'b0010, 1, 4'b0, 4'b0);
        drive(4'b0010, 1);
        step("regrant ack", 4'b0010, 1, 4'b0010, 4'b0);
        drive(4'b0, 0);
        step("to idle", 4'b0, 0, 4'b0, 4'b0);

        // Ack on the last watchdog cycle wins.
        drive(4'b0100, 0);
        step("race c0", 4'b0, 0, 4'b0, 4'b0);
        for (int c = 1; c <= 7; c++) begin
            step($sformatf("race c%0d", c), 4'b0100, 1, 4'b0, 4'b0);
        end
        drive(4'b0100, 1);
        step("race ack", 4'b0100, 1, 4'b0100, 4'b0);
        drive(4'b0, 0);
        step("race idle", 4'b0, 0, 4'b0, 4'b0);

        // Master 2 aborts; master 3 waits for the drain.
        drive(4'b0100, 0);
        step("abort c0", 4'b0, 0, 4'b0, 4'b0);
        drive(4'b1100, 0);
        step("abort c1", 4'b0100, 1, 4'b0, 4'b0);
        step("abort c2", 4'b0100, 1, 4'b0, 4'b0);
        drive(4'b1000, 0);
        step("abort drop", 4'b0100, 0, 4'b0, 4'b0);
        step("abort c4", 4'b0100, 0, 4'b0, 4'b0);
        step("abort c5", 4'b0100, 0, 4'b0, 4'b0);
        drive(4'b1000, 1);
        step("abort ack", 4'b0100, 0, 4'b0, 4'b0);
        drive(4'b1000, 0);
        step("abort idle", 4'b0, 0, 4'b0, 4'b0);
        step("m3 grant", 4'b1000, 1, 4'b0, 4'b0);
        drive(4'b1000, 1);
        step("m3 ack", 4'b1000, 1, 4'b1000, 4'b0);
        drive(4'b0, 0);
        step("m3 idle", 4'b0, 0, 4'b0, 4'b0);

        // Reset mid-GRANT after moving the pointer away from 0.
        drive(4'b0010, 0);
        step("rst c0", 4'b0, 0, 4'b0, 4'b0);
        step("rst c1", 4'b0010, 1, 4'b0, 4'b0);
        drive(4'b0010, 1);
        step("rst c2", 4'b0010, 1, 4'b0010, 4'b0);
        drive(4'b0100, 0);
        step("rst c3", 4'b0, 0, 4'b0, 4'b0);
        step("rst c4", 4'b0100, 1, 4'b0, 4'b0);
        wb_rst = 1'b1;
        step("rst c5", 4'b0100, 1, 4'b0, 4'b0);
        wb_rst = 1'b0;
        drive(4'b1111, 1);
        step("rst after", 4'b0, 0, 4'b0, 4'b0);
        drive(4'b1111, 0);
        step("rst ptr0", 4'b0001, 1, 4'b0, 4'b0);
        drive(4'b1111, 1);
        step("rst ptr0 ack", 4'b0001, 1, 4'b0001, 4'b0);
        drive(4'b0, 0);
        step("rst end", 4'b0, 0, 4'b0, 4'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
